eka_icache_v1: RTL and testbench
================================

# eka_icache_v1

Direct-mapped, read-only instruction cache placed between the Eka single-cycle core's fetch port and a backing instruction memory. Hits return the instruction combinationally in the same cycle, which preserves single-cycle fetch timing. On a miss the cache asserts `stall` to freeze the core PC, fetches the whole line from memory over a valid/ready request channel and a beat-per-word response channel, then resumes. A `flush` input invalidates all lines, for fence.i and program reload.

## Interface
- ADDR_WIDTH, 32, width of byte address from core and to memory
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2
- NUM_LINES, 16, number of lines; power of two, ≥2
- clk  in  1  processor clock
- reset  in  1  asynchronous, active-low reset
- inst_addr  in  ADDR_WIDTH  fetch byte address from core; bits [1:0] ignored
- instruction  out  32  fetched word; valid when stall=0
- stall  out  1  1 = miss in progress; core must hold PC and inst_addr
- flush  in  1  invalidate all lines (single-cycle pulse)
- mem_req_valid  out  1  line-refill request
- mem_req_addr  out  ADDR_WIDTH  line-aligned byte address (offset bits zero)
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  response beat valid
- mem_rsp_data  in  32  response word, ascending word order within line

## Operation
- Address split: offset = [log2(LINE_WORDS)+1:2]; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Per line: valid bit and tag register; data array NUM_LINES×LINE_WORDS words.
- Hit = IDLE ∧ valid[index] ∧ tag match. Hit: instruction = data[index][offset], stall=0. In any other case stall=1 and instruction = 32'h0000_0013 (NOP).
- FSM states:
  - IDLE. On a miss, latch the line address and go to REQ.
  - REQ. Hold mem_req_valid=1 and mem_req_addr stable until mem_req_ready. On the handshake edge, go to FILL with beat counter=0.
  - FILL. Each mem_rsp_valid writes mem_rsp_data to data[latched index][counter] and increments the counter. The beat with counter=LINE_WORDS-1 sets the tag and valid for the latched index, then the FSM goes to IDLE.
- mem_rsp_valid is ignored outside FILL. A gap with no beat leaves the state unchanged.
- Refill always uses the latched address. If inst_addr changes mid-miss (a core protocol violation), the latched line still fills, and IDLE re-evaluates the new address.
- flush in IDLE: all valid bits clear at the next edge.
- flush in REQ/FILL: all valid bits clear, and a sticky drop flag is set. The refill still completes its handshake and all beats, but its valid bit is not set. The drop flag clears on return to IDLE.
- flush on the final FILL beat: the valid bit is not set; flush wins.
- Reset (asynchronous, low): state=IDLE, all valid=0, counter=0, drop flag=0, mem_req_valid=0, mem_req_addr=0. A reset during REQ/FILL abandons the refill. Late response beats after reset are ignored.
- Data array contents are not reset.

## Timing
- Hit latency: 0 cycles (combinational from inst_addr).
- Miss with immediate ready and back-to-back beats:
  - cycle 0: miss detected, stall=1.
  - cycle 1: REQ, handshake.
  - cycles 2..LINE_WORDS+1: beats.
  - cycle LINE_WORDS+2: IDLE, hit, stall=0.
  - Minimum penalty: LINE_WORDS+2 cycles (6 at default).
- stall rises combinationally in the miss cycle and falls in the first cycle the refilled line hits.
- Reset values of outputs: stall=1 only if inst_addr misses (it always does after reset); instruction=NOP; mem_req_valid=0; mem_req_addr=0.

## Structure
- Package `eka_icache_pkg`:
  - state enum {IDLE, REQ, FILL};
  - NOP constant 32'h0000_0013;
  - functions deriving OFFSET_BITS/INDEX_BITS/TAG_BITS from the parameters.
- Sub-module `eka_icache_data_ram`: NUM_LINES*LINE_WORDS×32 array, one synchronous write port, one asynchronous read port, no reset.
- Tags, valid bits, FSM, counter and drop flag live in the top.

## Test plan
- Cold miss: reset, then inst_addr=0x0000_0000. Memory returns 0xA0,0xA1,0xA2,0xA3 with ready=1 each cycle. Expect mem_req_addr=0x0, stall=1 for 6 cycles, then instruction=0xA0. inst_addr=0xC then gives 0xA3 with stall=0.
- Conflict: after line 0x000 is filled, inst_addr=0x100 (same index, different tag) → refill request at 0x100. Returning to 0x000 misses again.
- Backpressure and gaps: mem_req_ready held low 3 cycles, then one idle cycle between each beat. Expect mem_req_addr stable, stall held throughout, correct words stored, penalty 6+3+3=12 cycles.
- Flush: flush pulse in IDLE after a fill → next access to 0x0 misses. Flush during FILL beat 2 → all 4 beats consumed, line stays invalid, next access re-requests.
- Reset mid-fill: reset asserted during FILL → mem_req_valid=0 immediately. Stray mem_rsp_valid beats are ignored, and the first access after release misses.

Source files
------------

// File: rtl/eka_icache_pkg.sv
// eka_icache_pkg: shared FSM type, NOP constant and address-geometry helpers
package eka_icache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_bits(input int addr_width, input int line_words, input int num_lines);
    return addr_width - 2 - $clog2(line_words) - $clog2(num_lines);
  endfunction
endpackage

// File: rtl/eka_icache_data_ram.sv
// eka_icache_data_ram: instruction word store, sync write from refill, async read for fetch
module eka_icache_data_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  // one refill beat per edge; contents are never reset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/eka_icache_v1.sv
// eka_icache_v1: direct-mapped read-only instruction cache with line refill over valid/ready
module eka_icache_v1
  import eka_icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           instruction,
  output logic                  stall,
  input  logic                  flush,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data
);
  localparam int OB = offset_bits(LINE_WORDS);
  localparam int IB = index_bits(NUM_LINES);
  localparam int TB = tag_bits(ADDR_WIDTH, LINE_WORDS, NUM_LINES);
  localparam int LB = IB + TB;
  localparam logic [OB-1:0] LAST = OB'(LINE_WORDS - 1);

  state_t               r_state, w_next;
  logic [NUM_LINES-1:0] r_valid;
  logic [TB-1:0]        r_tag [NUM_LINES];
  logic [LB-1:0]        r_line;
  logic [OB-1:0]        r_cnt;
  logic                 r_drop;
  logic [OB-1:0]        w_off;
  logic [IB-1:0]        w_idx;
  logic [TB-1:0]        w_tag;
  logic                 w_hit, w_beat, w_last, w_unused;
  logic [31:0]          w_rdata;

  assign w_off    = inst_addr[OB+1:2];
  assign w_idx    = inst_addr[OB+IB+1:OB+2];
  assign w_tag    = inst_addr[ADDR_WIDTH-1:OB+IB+2];
  assign w_unused = ^inst_addr[1:0];

  assign w_hit  = (r_state == IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_beat = (r_state == FILL) && mem_rsp_valid;
  assign w_last = w_beat && (r_cnt == LAST);

  assign stall         = !w_hit;
  assign instruction   = w_hit ? w_rdata : NOP;
  assign mem_req_valid = (r_state == REQ);
  assign mem_req_addr  = {r_line, {(OB+2){1'b0}}};

  // state register; reset abandons any refill in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;

  // miss starts a request, handshake starts the fill, last beat returns to idle
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && !w_hit) w_next = REQ;
    else if (r_state == REQ && mem_req_ready) w_next = FILL;
    else if (w_last) w_next = IDLE;
  end

  // latched line, beat counter, drop flag and valid bits; flush always wins over a completing fill
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_valid <= '0;
      r_line  <= '0;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
    end else begin
      if (r_state == IDLE && !w_hit) r_line <= {w_tag, w_idx};
      if (r_state == REQ) r_cnt <= '0;
      else if (w_beat) r_cnt <= r_cnt + OB'(1);
      if (w_last) r_drop <= 1'b0;
      else if (flush && r_state != IDLE) r_drop <= 1'b1;
      if (flush) r_valid <= '0;
      else if (w_last && !r_drop) r_valid[r_line[IB-1:0]] <= 1'b1;
    end

  // tag captured on the final beat; meaningless until its valid bit is set, so unreset
  always_ff @(posedge clk)
    if (w_last) r_tag[r_line[IB-1:0]] <= r_line[LB-1:IB];

  eka_icache_data_ram #(.DEPTH(NUM_LINES * LINE_WORDS)) u_ram (
    .clk    (clk),
    .i_we   (w_beat),
    .i_waddr({r_line[IB-1:0], r_cnt}),
    .i_wdata(mem_rsp_data),
    .i_raddr({w_idx, w_off}),
    .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_eka_icache_v1.sv
// tb_eka_icache_v1: directed and randomized fetch traffic checked against a line-level cache model
module tb_eka_icache_v1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic [31:0] instruction;
  logic        stall;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  int checks = 0;
  int failures = 0;

  bit          m_valid [16];
  int unsigned m_tag   [16];

  eka_icache_v1 dut (
    .clk          (clk),
    .reset        (reset),
    .inst_addr    (inst_addr),
    .instruction  (instruction),
    .stall        (stall),
    .flush        (flush),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a < 32'd16) return 32'hA0 + (a >> 2);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // one fetch; on a miss, serve the refill with rdly cycles of backpressure and gap idle cycles
  // between beats, optionally flushing on beat fb, which forces a re-request of the same line
  task automatic fetch(input logic [31:0] a, input int rdly, input int gap, input int fb, input bit stray);
    int idx, f;
    int unsigned tag;
    bit done;
    idx = int'((a >> 4) & 32'hF);
    tag = a >> 8;
    f = fb;
    done = 1'b0;
    @(negedge clk);
    inst_addr = a;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = stray;
    mem_rsp_data = 32'hDEAD_BEEF;
    #1;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      chk("hit_stall", stall, 0);
      chk("hit_data", instruction, memw(a & ~32'h3));
      return;
    end
    chk("miss_stall", stall, 1);
    chk("miss_nop", instruction, NOP);
    while (!done) begin
      for (int i = 0; i <= rdly; i++) begin
        @(negedge clk);
        flush = 1'b0;
        mem_req_ready = (i == rdly);
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_data = $urandom;
        #1;
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, a & ~32'hF);
        chk("req_stall", stall, 1);
      end
      for (int k = 0; k < 4; k++) begin
        for (int g = 0; g < (k == 0 ? 0 : gap); g++) begin
          @(negedge clk);
          mem_req_ready = 1'b0;
          mem_rsp_valid = 1'b0;
          flush = 1'b0;
          #1;
          chk("gap_stall", stall, 1);
          chk("gap_req_valid", mem_req_valid, 0);
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = memw((a & ~32'hF) + 32'(4 * k));
        flush = (k == f);
        #1;
        chk("fill_stall", stall, 1);
        chk("fill_req_valid", mem_req_valid, 0);
      end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      flush = 1'b0;
      #1;
      if (f < 0) begin
        m_valid[idx] = 1'b1;
        m_tag[idx] = tag;
        chk("done_stall", stall, 0);
        chk("done_data", instruction, memw(a & ~32'h3));
        done = 1'b1;
      end else begin
        clear_model();
        chk("drop_stall", stall, 1);
        chk("drop_nop", instruction, NOP);
        f = -1;
      end
    end
  endtask

  // flush pulse while the current address hits in IDLE
  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    chk("flush_cycle_stall", stall, 0);
    clear_model();
  endtask

  // reset asserted in the middle of a fill, stray beats while held, released just after a posedge
  task automatic reset_mid_fill(input logic [31:0] a);
    @(negedge clk);
    inst_addr = a;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk("rmf_miss", stall, 1);
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    chk("rmf_req", mem_req_valid, 1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hBAD0_0000;
    #1;
    chk("rmf_fill_req", mem_req_valid, 0);
    @(negedge clk);
    mem_rsp_data = 32'hBAD0_0001;
    #1;
    reset = 1'b0;
    #1;
    clear_model();
    chk("rmf_req_valid", mem_req_valid, 0);
    chk("rmf_req_addr", mem_req_addr, 0);
    chk("rmf_stall", stall, 1);
    chk("rmf_nop", instruction, NOP);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_data = $urandom;
    end
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b0;
    inst_addr = 32'h0;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;
    clear_model();
    @(negedge clk);
    #1;
    chk("rst_stall", stall, 1);
    chk("rst_nop", instruction, NOP);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    // cold miss then hits within the line
    fetch(32'h0, 0, 0, -1, 0);
    fetch(32'hC, 0, 0, -1, 0);
    fetch(32'h4, 0, 0, -1, 1);
    fetch(32'h9, 0, 0, -1, 0);
    // conflict on index 0
    fetch(32'h100, 0, 0, -1, 0);
    fetch(32'h0, 0, 0, -1, 0);
    // backpressure and gaps
    fetch(32'h344, 3, 1, -1, 1);
    fetch(32'h34C, 0, 0, -1, 0);
    // flush in IDLE, then flush during fill beat 2 and on the final beat
    do_flush();
    fetch(32'h0, 0, 0, -1, 0);
    fetch(32'h50, 0, 0, 2, 0);
    fetch(32'h54, 0, 0, -1, 0);
    fetch(32'h60, 1, 1, 3, 0);
    fetch(32'h68, 0, 0, -1, 0);
    // reset mid-fill
    reset_mid_fill(32'h70);
    fetch(32'h70, 0, 0, -1, 1);
    fetch(32'h0, 0, 0, -1, 0);
    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom);
      fetch(a, $urandom_range(0, 2), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) do_flush();
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
